// File: rtl/mem_byte_sequencer.sv
// -----------------------------------------------------------------------------
// mem_byte_sequencer
//
// Bridges a 32-bit byte/half/word load/store port to an 8-bit single-port
// memory. Each request becomes 1, 2 or 4 sequential little-endian byte beats.
// Load bytes are gathered into a buffer and returned sign- or zero-extended.
// Each request gets exactly one response.
//
// Optional feature macro: ALIGN_CHECK_EN
//   defined   : misaligned half/word requests skip memory entirely and
//               respond with resp_err=1, resp_rdata=0.
//   undefined : misaligned requests run bytewise like aligned ones, and
//               resp_err is constant 0.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   req_*             request channel (valid/ready), we/size/signed/addr/wdata
//   resp_*            response channel (valid/ready), rdata/err
//   mem_cs/we/addr    memory beat command; mem_data_in is the store byte
//   mem_data_out      combinational read byte from memory
//   mem_vld           current beat completes at this clock edge
//   dbg_state         current FSM state, for observation only
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A source keeps valid and payload stable until that edge. Here
// req_ready is high only in IDLE. resp_valid stays high with a stable
// payload until resp_ready is seen.
// -----------------------------------------------------------------------------
module mem_byte_sequencer #(
   parameter int ADDR_WIDTH     = 32,
   parameter int MEM_ADDR_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_we,
   input  logic [1:0]                req_size,
   input  logic                      req_signed,
   input  logic [ADDR_WIDTH-1:0]     req_addr,
   input  logic [31:0]               req_wdata,
   output logic                      resp_valid,
   input  logic                      resp_ready,
   output logic [31:0]               resp_rdata,
   output logic                      resp_err,
   output logic                      mem_cs,
   output logic                      mem_we,
   output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
   output logic [7:0]                mem_data_in,
   input  logic [7:0]                mem_data_out,
   input  logic                      mem_vld,
   output logic [1:0]                dbg_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BEAT = 2'd1,
      RESP = 2'd2
   } state_e;

   state_e                    state_q, state_d;
   logic                      we_q, we_d;
   logic [1:0]                size_q, size_d;
   logic                      signed_q, signed_d;
   logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]               wdata_q, wdata_d;
   logic [1:0]                cnt_q, cnt_d;
   logic [31:0]               rbuf_q, rbuf_d;
`ifdef ALIGN_CHECK_EN
   logic                      err_q, err_d;
   logic                      misalign;
`endif

   logic [1:0]  last_cnt;
   logic [31:0] load_val;

   // Index of the final beat: 0 for byte, 1 for half, 3 for word (size 3 too).
   assign last_cnt = (size_q == 2'd0) ? 2'd0 : (size_q == 2'd1) ? 2'd1 : 2'd3;

   // Extension of the gathered bytes; bytes above the access size are ignored.
   always_comb begin
      load_val = rbuf_q;
      unique case (size_q)
         2'd0:    load_val = {{24{signed_q & rbuf_q[7]}}, rbuf_q[7:0]};
         2'd1:    load_val = {{16{signed_q & rbuf_q[15]}}, rbuf_q[15:0]};
         default: load_val = rbuf_q;
      endcase
   end

`ifdef ALIGN_CHECK_EN
   assign misalign = ((req_size == 2'd1) && req_addr[0]) ||
                     (req_size[1] && (req_addr[1:0] != 2'b00));
`endif

   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      size_d      = size_q;
      signed_d    = signed_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      cnt_d       = cnt_q;
      rbuf_d      = rbuf_q;
`ifdef ALIGN_CHECK_EN
      err_d       = err_q;
`endif
      req_ready   = 1'b0;
      resp_valid  = 1'b0;
      resp_rdata  = 32'h0;
      resp_err    = 1'b0;
      mem_cs      = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_data_in = 8'h0;

      unique case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               we_d     = req_we;
               size_d   = req_size;
               signed_d = req_signed;
               addr_d   = MEM_ADDR_WIDTH'(req_addr);
               wdata_d  = req_wdata;
               cnt_d    = 2'd0;
               rbuf_d   = 32'h0;
               state_d  = BEAT;
`ifdef ALIGN_CHECK_EN
               err_d    = misalign;
               if (misalign) state_d = RESP;
`endif
            end
         end
         BEAT: begin
            mem_cs      = 1'b1;
            mem_we      = we_q;
            // Byte address wraps naturally at the memory address width.
            mem_addr    = addr_q + MEM_ADDR_WIDTH'(cnt_q);
            mem_data_in = wdata_q[{cnt_q, 3'b000} +: 8];
            if (mem_vld) begin
               if (!we_q) rbuf_d[{cnt_q, 3'b000} +: 8] = mem_data_out;
               if (cnt_q == last_cnt) state_d = RESP;
               else                   cnt_d   = cnt_q + 2'd1;
            end
         end
         RESP: begin
            resp_valid = 1'b1;
`ifdef ALIGN_CHECK_EN
            resp_err   = err_q;
            resp_rdata = (we_q || err_q) ? 32'h0 : load_val;
`else
            resp_rdata = we_q ? 32'h0 : load_val;
`endif
            if (resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         we_q     <= 1'b0;
         size_q   <= 2'd0;
         signed_q <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= 32'h0;
         cnt_q    <= 2'd0;
         rbuf_q   <= 32'h0;
`ifdef ALIGN_CHECK_EN
         err_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         size_q   <= size_d;
         signed_q <= signed_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         cnt_q    <= cnt_d;
         rbuf_q   <= rbuf_d;
`ifdef ALIGN_CHECK_EN
         err_q    <= err_d;
`endif
      end
   end

   assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_byte_sequencer.sv
module tb_mem_byte_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_we, req_signed;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_rdata;
   logic        mem_cs, mem_we, mem_vld;
   logic [31:0] mem_addr;
   logic [7:0]  mem_data_in, mem_data_out;
   logic [1:0]  dbg_state;

   int n_tests = 0;
   int n_fail  = 0;

   // Environment memory (what the DUT talks to) and the reference copy.
   logic [7:0] mem [0:255];
   logic [7:0] ref_mem [0:255];
   logic       load_mem;

   logic [31:0] last_rdata;
   logic        last_err;
   int          last_cs;

   always #5 clk = ~clk;

   mem_byte_sequencer #(.ADDR_WIDTH(32), .MEM_ADDR_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
      .mem_vld(mem_vld), .dbg_state(dbg_state)
   );

   function automatic logic [7:0] init_byte(input int i);
      logic [63:0] pre;
      pre = 64'h8877665584332211;
      if (i < 8) return pre[8*i +: 8];
      return 8'(i * 7 + 3);
   endfunction

   always @(posedge clk) begin
      if (load_mem) begin
         for (int i = 0; i < 256; i++) mem[i] <= init_byte(i);
      end else if (mem_cs && mem_we && mem_vld) begin
         mem[mem_addr[7:0]] <= mem_data_in;
      end
   end
   assign mem_data_out = mem[mem_addr[7:0]];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Reference: what a load/store should return, computed bytewise from the
   // little-endian rules, updating the reference memory for stores.
   function automatic void ref_model(input logic we, input logic [1:0] size, input logic sgn,
                                     input logic [31:0] addr, input logic [31:0] wdata,
                                     output logic [31:0] rdata, output logic err, output int nb);
      logic [31:0] val;
      nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
`ifdef ALIGN_CHECK_EN
      if ((nb == 2 && addr[0]) || (nb == 4 && addr[1:0] != 2'b00)) begin
         rdata = 32'h0; err = 1'b1; nb = 0;
         return;
      end
`endif
      err = 1'b0;
      val = 32'h0;
      for (int i = 0; i < nb; i++) begin
         if (we) ref_mem[(addr + i) % 256] = 8'((wdata >> (8 * i)) & 32'hFF);
         else    val = val | (32'(ref_mem[(addr + i) % 256]) << (8 * i));
      end
      if (we)                         rdata = 32'h0;
      else if (nb == 1 && sgn && val[7])  rdata = val | 32'hFFFF_FF00;
      else if (nb == 2 && sgn && val[15]) rdata = val | 32'hFFFF_0000;
      else                            rdata = val;
   endfunction

   // One full transaction. Called at a negedge with the DUT idle.
   task automatic txn(input logic we, input logic [1:0] size, input logic sgn,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input int stall_beat, input int stall_cyc, input int rr_stall);
      logic [31:0] exp_q[$];
      logic [31:0] exp_rdata;
      logic        exp_err;
      int nb, beats_done, cs_cycles, stalled, resp_cyc, stall_eff;
      ref_model(we, size, sgn, addr, wdata, exp_rdata, exp_err, nb);
      exp_q.push_back(exp_rdata);
      stall_eff = (stall_beat < nb) ? stall_cyc : 0;

      check("req_ready_idle", req_ready, 1'b1);
      req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
      req_addr = addr; req_wdata = wdata; mem_vld = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;

      beats_done = 0; cs_cycles = 0; stalled = 0; resp_cyc = -1;
      for (int cyc = 0; cyc < 60; cyc++) begin
         if (resp_valid) begin
            resp_cyc = cyc;
            break;
         end
         check("req_ready_busy", req_ready, 1'b0);
         if (mem_cs) begin
            cs_cycles++;
            check("mem_addr", mem_addr, addr + 32'(beats_done));
            check("mem_we", mem_we, we);
            if (we) check("mem_data_in", mem_data_in, 32'((wdata >> (8 * beats_done)) & 32'hFF));
            if (beats_done == stall_beat && stalled < stall_cyc) begin
               mem_vld = 1'b0;
               stalled++;
            end else begin
               mem_vld = 1'b1;
               beats_done++;
            end
         end else begin
            check("mem_we_no_cs", mem_we, 1'b0);
            mem_vld = 1'b1;
         end
         @(negedge clk);
      end
      mem_vld = 1'b1;
      check("resp_seen", (resp_cyc >= 0) ? 1'b1 : 1'b0, 1'b1);
      if (resp_cyc < 0) return;
      check("resp_latency", resp_cyc, nb + stall_eff);
      check("cs_cycles", cs_cycles, nb + stall_eff);
      last_cs    = cs_cycles;
      last_rdata = resp_rdata;
      last_err   = resp_err;

      for (int k = 0; k <= rr_stall; k++) begin
         check("resp_valid", resp_valid, 1'b1);
         check("resp_rdata", resp_rdata, exp_q[0]);
         check("resp_err", resp_err, exp_err);
         check("cs_in_resp", mem_cs, 1'b0);
         check("req_ready_resp", req_ready, 1'b0);
         if (k == rr_stall) resp_ready = 1'b1;
         @(negedge clk);
         resp_ready = 1'b0;
      end
      void'(exp_q.pop_front());
      check("resp_done", resp_valid, 1'b0);
      check("back_idle", req_ready, 1'b1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"}, req_ready, 1'b1);
      check({tag, "_resp_valid"}, resp_valid, 1'b0);
      check({tag, "_resp_rdata"}, resp_rdata, 32'h0);
      check({tag, "_resp_err"}, resp_err, 1'b0);
      check({tag, "_mem_cs"}, mem_cs, 1'b0);
      check({tag, "_mem_we"}, mem_we, 1'b0);
      check({tag, "_mem_addr"}, mem_addr, 32'h0);
      check({tag, "_mem_data_in"}, mem_data_in, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // clock / reset
      rst_n = 1'b0; load_mem = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
      req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0; mem_vld = 1'b1;
      for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1; load_mem = 1'b0;
      @(negedge clk);

      // 1: word load at 0
      txn(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 9, 0, 0);
      check("t1_word", last_rdata, 32'h84332211);

      // 2: byte load at 3, signed then unsigned
      txn(1'b0, 2'd0, 1'b1, 32'h3, 32'h0, 9, 0, 0);
      check("t2_signed", last_rdata, 32'hFFFFFF84);
      check("t2_cs_signed", last_cs, 1);
      txn(1'b0, 2'd0, 1'b0, 32'h3, 32'h0, 9, 0, 0);
      check("t2_unsigned", last_rdata, 32'h00000084);
      check("t2_cs_unsigned", last_cs, 1);

      // 3: word store then load back
      txn(1'b1, 2'd2, 1'b0, 32'h4, 32'hDEADBEEF, 9, 0, 0);
      check("t3_store_rdata", last_rdata, 32'h0);
      txn(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, 9, 0, 0);
      check("t3_load", last_rdata, 32'hDEADBEEF);

      // 4: memory stall on beat 1 and response back-pressure
      txn(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, 1, 3, 2);
      check("t4_load", last_rdata, 32'hDEADBEEF);
      check("t4_cs", last_cs, 7);

      // 6: misaligned half load at 1
      txn(1'b0, 2'd1, 1'b0, 32'h1, 32'h0, 9, 0, 0);
`ifdef ALIGN_CHECK_EN
      check("t6_err", last_err, 1'b1);
      check("t6_rdata", last_rdata, 32'h0);
      check("t6_cs", last_cs, 0);
`else
      check("t6_rdata", last_rdata, 32'h00003322);
      check("t6_err", last_err, 1'b0);
`endif

      // 5: reset during the second beat of a word store at 0
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_signed = 1'b0;
      req_addr = 32'h0; req_wdata = 32'hA5B6C7D8; mem_vld = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      check("t5_beat0_addr", mem_addr, 32'h0);
      @(negedge clk);
      check("t5_beat1_addr", mem_addr, 32'h1);
      rst_n = 1'b0;
      @(negedge clk);
      check_reset_outputs("t5");
      rst_n = 1'b1;
      ref_mem[0] = 8'hD8;
      ref_mem[1] = 8'hC7;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t5_no_resp", resp_valid, 1'b0);
      end
      check("t5_mem0", mem[0], 32'hD8);
      check("t5_mem1", mem[1], 32'hC7);
      check("t5_mem2", mem[2], 32'h33);
      check("t5_mem3", mem[3], 32'h84);
      txn(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 9, 0, 0);
      check("t5_load", last_rdata, 32'h8433C7D8);

      // randomized traffic against the reference model
      for (int n = 0; n < 40; n++) begin
         txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             32'($urandom_range(0, 15)), $urandom,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
